mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the unified instruction/data memory of the multi-cycle MIPS processor. It shares one fixed-latency synchronous memory between two requesters:
- the CPU port, driven by the multi-cycle control unit's memory accesses;
- a loader port, used by the boot/program loader and debug writes.

The block latches each request, holds the memory signals stable for the memory latency, and returns read data with a one-cycle acknowledge. The control FSM holds its state while `cpu_stall` is high.

## Interface
Parameters:
- `AW`, 32, byte-address width of both requester ports.
- `DW`, 32, data width.
- `LATENCY`, 2, memory read latency in cycles (legal range 1..15); number of BUSY cycles per access.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU access request; level, held until `cpu_ack`.
- `cpu_we` in 1: CPU write enable, qualified by `cpu_req`.
- `cpu_addr` in AW: CPU byte address.
- `cpu_wdata` in DW: CPU write data.
- `cpu_rdata` out DW: CPU read-data register.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_stall` out 1: `cpu_req & ~cpu_ack`, combinational.
- `cpu_hold` in 1: when high, CPU requests are not granted (loader owns memory).
- `ldr_req`, `ldr_we`, `ldr_addr` (AW), `ldr_wdata` (DW), `ldr_rdata` (DW, out), `ldr_ack` (out): loader port, same semantics as the CPU port.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW-2: word address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data.

## Operation
FSM states: IDLE, BUSY, ACK.

IDLE:
- `mem_en=0`.
- Eligible requests: `ldr_req`, and `cpu_req & ~cpu_hold`.
- One eligible request: grant it.
- Both eligible: grant the port that was not granted last (`last_grant` register; reset value CPU, so the loader wins the first tie).
- On grant, latch `owner`, `we`, `addr[AW-1:2]`, `wdata`; set `cnt=LATENCY-1`; update `last_grant`; go to BUSY.
- `addr[1:0]` is ignored (word accesses only).

BUSY:
- `mem_en=1`; `mem_we`, `mem_addr`, `mem_wdata` come from the latched registers and are stable for every BUSY cycle.
- If `cnt!=0`: decrement `cnt`.
- If `cnt==0`:
  - On reads, capture `mem_rdata` into the owner's rdata register.
  - On writes, leave the owner's rdata register unchanged.
  - Go to ACK.

ACK:
- Owner's ack=1 for exactly one cycle; `mem_en=0`.
- Requests are not sampled in this cycle; go to IDLE.
- A req still high in the following IDLE cycle is a new request.

Rules and boundary conditions:
- rdata registers hold their value until the next read completes for that port.
- The non-owner's ack is never asserted.
- A requester that drops req mid-access: the access still completes and ack still pulses.
- A change to port inputs after grant has no effect on the access in progress.
- `cpu_hold` rising during a CPU access does not abort it; it only blocks future CPU grants.
- `cpu_hold` high with only `cpu_req`: the arbiter stays in IDLE and `cpu_stall=1` indefinitely.

Reset, in any state, takes effect next edge:
- state=IDLE, `cnt=0`, `owner=CPU`, `last_grant=CPU`.
- `cpu_ack=ldr_ack=0`, `mem_en=mem_we=0`.
- `mem_addr`, `mem_wdata`, `cpu_rdata`, `ldr_rdata` = 0.
- An access interrupted by reset is abandoned with no ack.

## Timing
- req first seen in IDLE at edge T → BUSY in cycles T+1..T+LATENCY → ack high in cycle T+LATENCY+1, rdata valid in that same cycle.
- Request-to-ack latency is LATENCY+1 cycles; back-to-back throughput is one access per LATENCY+2 cycles (ACK and IDLE add one cycle each).
- Memory contract: data at the address presented on the first BUSY cycle is valid on `mem_rdata` in the last BUSY cycle (`cnt==0`).
- Writes commit on the first BUSY edge with `mem_we=1`; the memory tolerates the repeated identical writes in later BUSY cycles.
- All outputs are registered except `cpu_stall`.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding localparams (IDLE=2'd0, BUSY=2'd1, ACK=2'd2);
  - owner encoding (OWN_CPU=1'b0, OWN_LDR=1'b1);
  - a 4-bit counter width constant.
- Single module; no sub-module needed. The latency counter and round-robin bit are small enough to stay inline.

## Test plan
- **Single CPU read**, `LATENCY=2`, memory word 0x10 (byte 0x40) = 0xDEADBEEF: `cpu_req` with addr 0x40 → `mem_addr=0x10` for 2 cycles, `cpu_ack` at T+3, `cpu_rdata=0xDEADBEEF`, `cpu_stall` high from T through T+2.
- **Loader write then CPU read**: loader writes 0x12345678 to 0x80, then CPU reads 0x80 → `ldr_ack` pulses once, `ldr_rdata` unchanged, CPU reads 0x12345678.
- **Simultaneous requests after reset**: both ports request repeatedly → grants strictly alternate LDR, CPU, LDR, CPU; each ack is exactly one cycle and only to the owner.
- **`cpu_hold=1` with both requesting**: only loader accesses occur and `cpu_stall` stays 1. Drop `cpu_hold` → CPU is granted in the next IDLE cycle.
- **Reset asserted during BUSY**: no ack is produced; next cycle all outputs are 0 and the state is IDLE. A new request after reset completes with the normal LATENCY+1 latency.
- **`LATENCY=1` and `LATENCY=15` builds**: ack is at T+2 and T+16 respectively; `mem_en` is high for exactly LATENCY cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state
// encoding, owner encoding, latency counter width and the round-robin pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    localparam int CNT_W = 4;

    // Select the winner among the eligible ports. On a tie the port that was
    // not granted last wins, so continuous contention alternates.
    function automatic logic rr_pick(input logic cpu_elig,
                                     input logic ldr_elig,
                                     input logic last_grant);
        logic pick;
        if (cpu_elig && ldr_elig) begin
            pick = (last_grant == OWN_CPU) ? OWN_LDR : OWN_CPU;
        end else if (ldr_elig) begin
            pick = OWN_LDR;
        end else begin
            pick = OWN_CPU;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer in front of a fixed-latency synchronous
// memory shared by the multi-cycle CPU and the boot/debug loader. Each grant
// latches the request, holds the memory signals for LATENCY cycles, captures
// read data into the owner's rdata register and pulses the owner's ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          cpu_hold,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic [DW-1:0] ldr_rdata,
    output logic          ldr_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter load value: LATENCY BUSY cycles means LATENCY-1 decrements.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    arb_state_e     state_r,      state_nxt_s;
    logic [CNT_W-1:0] cnt_r,      cnt_nxt_s;
    logic           owner_r,      owner_nxt_s;
    logic           last_grant_r, last_grant_nxt_s;
    logic           mem_en_r,     mem_en_nxt_s;
    logic           mem_we_r,     mem_we_nxt_s;
    logic [AW-3:0]  mem_addr_r,   mem_addr_nxt_s;
    logic [DW-1:0]  mem_wdata_r,  mem_wdata_nxt_s;
    logic [DW-1:0]  cpu_rdata_r,  cpu_rdata_nxt_s;
    logic [DW-1:0]  ldr_rdata_r,  ldr_rdata_nxt_s;
    logic           cpu_ack_r,    cpu_ack_nxt_s;
    logic           ldr_ack_r,    ldr_ack_nxt_s;

    logic           cpu_elig_s;
    logic           grant_sel_s;

    // Byte-lane bits are irrelevant: only whole words are transferred.
    logic           addr_lsb_unused_s;
    assign addr_lsb_unused_s = ^{cpu_addr[1:0], ldr_addr[1:0]};

    assign cpu_elig_s  = cpu_req & ~cpu_hold;
    assign grant_sel_s = rr_pick(cpu_elig_s, ldr_req, last_grant_r);

    // Next-state and next-output logic for the IDLE/BUSY/ACK sequencer.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        owner_nxt_s      = owner_r;
        last_grant_nxt_s = last_grant_r;
        mem_en_nxt_s     = 1'b0;
        mem_we_nxt_s     = 1'b0;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        cpu_rdata_nxt_s  = cpu_rdata_r;
        ldr_rdata_nxt_s  = ldr_rdata_r;
        cpu_ack_nxt_s    = 1'b0;
        ldr_ack_nxt_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (cpu_elig_s || ldr_req) begin
                    state_nxt_s      = BUSY;
                    owner_nxt_s      = grant_sel_s;
                    last_grant_nxt_s = grant_sel_s;
                    cnt_nxt_s        = CNT_LOAD;
                    mem_en_nxt_s     = 1'b1;
                    if (grant_sel_s == OWN_LDR) begin
                        mem_we_nxt_s    = ldr_we;
                        mem_addr_nxt_s  = ldr_addr[AW-1:2];
                        mem_wdata_nxt_s = ldr_wdata;
                    end else begin
                        mem_we_nxt_s    = cpu_we;
                        mem_addr_nxt_s  = cpu_addr[AW-1:2];
                        mem_wdata_nxt_s = cpu_wdata;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            BUSY: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_nxt_s    = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    mem_en_nxt_s = 1'b1;
                    mem_we_nxt_s = mem_we_r;
                end else begin
                    state_nxt_s = ACK;
                    // Read data is only captured for reads; writes leave the
                    // owner's rdata register untouched.
                    if (!mem_we_r && (owner_r == OWN_LDR)) begin
                        ldr_rdata_nxt_s = mem_rdata;
                    end else if (!mem_we_r) begin
                        cpu_rdata_nxt_s = mem_rdata;
                    end else begin
                        cpu_rdata_nxt_s = cpu_rdata_r;
                    end
                    if (owner_r == OWN_LDR) begin
                        ldr_ack_nxt_s = 1'b1;
                    end else begin
                        cpu_ack_nxt_s = 1'b1;
                    end
                end
            end

            ACK: begin
                // Requests are deliberately not sampled here.
                state_nxt_s = IDLE;
            end

            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered-output update with synchronous reset; an access
    // interrupted by reset is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            owner_r      <= OWN_CPU;
            last_grant_r <= OWN_CPU;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {(AW-2){1'b0}};
            mem_wdata_r  <= {DW{1'b0}};
            cpu_rdata_r  <= {DW{1'b0}};
            ldr_rdata_r  <= {DW{1'b0}};
            cpu_ack_r    <= 1'b0;
            ldr_ack_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            owner_r      <= owner_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            mem_en_r     <= mem_en_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            cpu_rdata_r  <= cpu_rdata_nxt_s;
            ldr_rdata_r  <= ldr_rdata_nxt_s;
            cpu_ack_r    <= cpu_ack_nxt_s;
            ldr_ack_r    <= ldr_ack_nxt_s;
        end
    end

    assign cpu_rdata = cpu_rdata_r;
    assign cpu_ack   = cpu_ack_r;
    assign ldr_rdata = ldr_rdata_r;
    assign ldr_ack   = ldr_ack_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_stall = cpu_req & ~cpu_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run scored against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_hold = 1'b0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [31:0] ldr_addr = 32'd0, ldr_wdata = 32'd0;
    logic [31:0] cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_stall, ldr_ack, mem_en, mem_we;
    logic [29:0] mem_addr;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] ref_mem [int];

    // Clock generation.
    always #5 clk = ~clk;

    // Power-on contents of a word not yet written.
    function automatic logic [31:0] init_word(input logic [7:0] w);
        if (w == 8'h10) return 32'hDEADBEEF;
        else return {8'hA5, w, ~w, 8'h3C};
    endfunction

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall), .cpu_hold(cpu_hold),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory behind the main instance: combinational read, write on edge.
    logic [31:0] tmem [256];
    logic        twritten [256];
    assign mem_rdata = twritten[mem_addr[7:0]] ? tmem[mem_addr[7:0]] : init_word(mem_addr[7:0]);

    // Memory write port; reset wipes it back to power-on contents.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) twritten[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            tmem[mem_addr[7:0]]     <= mem_wdata;
            twritten[mem_addr[7:0]] <= 1'b1;
        end
    end

    // Extra builds at the latency extremes, CPU-port reads only.
    logic        l1_req = 1'b0, l15_req = 1'b0;
    logic [31:0] lb_addr = 32'd0;
    logic [31:0] l1_rdata, l15_rdata, l1_ldr_rdata_unused, l15_ldr_rdata_unused;
    logic [31:0] l1_mwdata_unused, l15_mwdata_unused, l1_mrdata, l15_mrdata;
    logic        l1_ack, l15_ack, l1_ldr_ack, l15_ldr_ack, l1_en, l15_en;
    logic        l1_stall_unused, l15_stall_unused, l1_we_unused, l15_we_unused;
    logic [29:0] l1_maddr, l15_maddr;
    assign l1_mrdata  = init_word(l1_maddr[7:0]);
    assign l15_mrdata = init_word(l15_maddr[7:0]);

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .cpu_req(l1_req), .cpu_we(1'b0), .cpu_addr(lb_addr), .cpu_wdata(32'd0),
        .cpu_rdata(l1_rdata), .cpu_ack(l1_ack), .cpu_stall(l1_stall_unused), .cpu_hold(1'b0),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'd0), .ldr_wdata(32'd0),
        .ldr_rdata(l1_ldr_rdata_unused), .ldr_ack(l1_ldr_ack),
        .mem_en(l1_en), .mem_we(l1_we_unused), .mem_addr(l1_maddr), .mem_wdata(l1_mwdata_unused),
        .mem_rdata(l1_mrdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(15)) u_l15 (
        .clk(clk), .reset(reset),
        .cpu_req(l15_req), .cpu_we(1'b0), .cpu_addr(lb_addr), .cpu_wdata(32'd0),
        .cpu_rdata(l15_rdata), .cpu_ack(l15_ack), .cpu_stall(l15_stall_unused), .cpu_hold(1'b0),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'd0), .ldr_wdata(32'd0),
        .ldr_rdata(l15_ldr_rdata_unused), .ldr_ack(l15_ldr_ack),
        .mem_en(l15_en), .mem_we(l15_we_unused), .mem_addr(l15_maddr), .mem_wdata(l15_mwdata_unused),
        .mem_rdata(l15_mrdata)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_hold = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0;
        l1_req = 1'b0; l15_req = 1'b0;
        ref_mem.delete();
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0; cpu_hold = 1'b0;
        @(posedge clk); @(negedge clk);
        tests_run++; if (cpu_ack !== 1'b0) begin tests_failed++; $display("FAIL reset cpu_ack: got %b want 0", cpu_ack); end
        tests_run++; if (ldr_ack !== 1'b0) begin tests_failed++; $display("FAIL reset ldr_ack: got %b want 0", ldr_ack); end
        tests_run++; if ({mem_en, mem_we} !== 2'b00) begin tests_failed++; $display("FAIL reset mem_en/we: got %b want 00", {mem_en, mem_we}); end
        tests_run++; if (mem_addr !== 30'd0) begin tests_failed++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
        tests_run++; if (mem_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); end
        tests_run++; if ({cpu_rdata, ldr_rdata} !== 64'd0) begin tests_failed++; $display("FAIL reset rdata: got %h %h want 0", cpu_rdata, ldr_rdata); end
        tests_run++; if (cpu_stall !== 1'b0) begin tests_failed++; $display("FAIL reset cpu_stall: got %b want 0", cpu_stall); end
        reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        #1;
        tests_run++; if (cpu_stall !== 1'b1) begin tests_failed++; $display("FAIL read stall at T: got %b want 1", cpu_stall); end
        for (int k = 0; k < L + 2; k++) begin
            @(posedge clk); @(negedge clk);
            if (k < L) begin
                tests_run++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin tests_failed++; $display("FAIL read busy en/we k=%0d: got %b%b want 10", k, mem_en, mem_we); end
                tests_run++; if (mem_addr !== 30'h10) begin tests_failed++; $display("FAIL read mem_addr k=%0d: got %h want 10", k, mem_addr); end
                tests_run++; if (cpu_ack !== 1'b0 || cpu_stall !== 1'b1) begin tests_failed++; $display("FAIL read busy ack/stall k=%0d: got %b%b want 01", k, cpu_ack, cpu_stall); end
            end else if (k == L) begin
                tests_run++; if (cpu_ack !== 1'b1 || ldr_ack !== 1'b0) begin tests_failed++; $display("FAIL read ack: got cpu %b ldr %b want 1 0", cpu_ack, ldr_ack); end
                tests_run++; if (cpu_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL read rdata: got %h want deadbeef", cpu_rdata); end
                tests_run++; if (mem_en !== 1'b0 || cpu_stall !== 1'b0) begin tests_failed++; $display("FAIL read ack-cycle en/stall: got %b%b want 00", mem_en, cpu_stall); end
                cpu_req = 1'b0;
            end else begin
                tests_run++; if (cpu_ack !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL read after ack: got ack %b rdata %h want 0 deadbeef", cpu_ack, cpu_rdata); end
            end
        end
    endtask

    task automatic test_ldr_write_cpu_read();
        int acks;
        do_reset();
        acks = 0;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h80; ldr_wdata = 32'h12345678;
        for (int k = 0; k < L + 3; k++) begin
            @(posedge clk); @(negedge clk);
            if (k < L) begin
                tests_run++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 30'h20 || mem_wdata !== 32'h12345678) begin
                    tests_failed++; $display("FAIL ldr write busy k=%0d: got en %b we %b addr %h data %h", k, mem_en, mem_we, mem_addr, mem_wdata); end
            end
            tests_run++; if (cpu_ack !== 1'b0) begin tests_failed++; $display("FAIL ldr write cpu_ack: got %b want 0", cpu_ack); end
            if (ldr_ack === 1'b1) begin acks++; ldr_req = 1'b0; end
        end
        tests_run++; if (acks !== 1) begin tests_failed++; $display("FAIL ldr write ack count: got %0d want 1", acks); end
        tests_run++; if (ldr_rdata !== 32'd0) begin tests_failed++; $display("FAIL ldr write rdata kept: got %h want 0", ldr_rdata); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h81;
        for (int k = 0; k <= L; k++) begin
            @(posedge clk); @(negedge clk);
        end
        tests_run++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h12345678) begin
            tests_failed++; $display("FAIL cpu read-back: got ack %b rdata %h want 1 12345678", cpu_ack, cpu_rdata); end
        cpu_req = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_alternation();
        int nacks;
        logic exp_ldr, prev;
        do_reset();
        nacks = 0; exp_ldr = 1'b1; prev = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h8;
        for (int n = 0; n < 4 * (L + 2) + 2; n++) begin
            @(posedge clk); @(negedge clk);
            tests_run++; if (cpu_ack && ldr_ack) begin tests_failed++; $display("FAIL alt both acks n=%0d", n); end
            if (cpu_ack || ldr_ack) begin
                tests_run++; if (ldr_ack !== exp_ldr) begin tests_failed++; $display("FAIL alt order ack#%0d: got ldr %b want %b", nacks, ldr_ack, exp_ldr); end
                tests_run++; if (prev) begin tests_failed++; $display("FAIL alt ack width: got 2+ cycles want 1"); end
                exp_ldr = ~exp_ldr; nacks++;
            end
            prev = cpu_ack | ldr_ack;
        end
        tests_run++; if (nacks !== 4) begin tests_failed++; $display("FAIL alt ack count: got %0d want 4", nacks); end
    endtask

    task automatic test_hold();
        int lacks;
        do_reset();
        lacks = 0;
        cpu_hold = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h10;
        for (int n = 0; n < 3 * (L + 2); n++) begin
            @(posedge clk); @(negedge clk);
            tests_run++; if (cpu_ack !== 1'b0 || cpu_stall !== 1'b1) begin tests_failed++; $display("FAIL hold cpu n=%0d: got ack %b stall %b want 0 1", n, cpu_ack, cpu_stall); end
            if (ldr_ack) lacks++;
        end
        tests_run++; if (lacks !== 3) begin tests_failed++; $display("FAIL hold ldr acks: got %0d want 3", lacks); end
        cpu_hold = 1'b0;
        for (int n = 0; n <= L; n++) begin
            @(posedge clk); @(negedge clk);
            tests_run++; if (cpu_ack !== (n == L) || ldr_ack !== 1'b0) begin
                tests_failed++; $display("FAIL hold release n=%0d: got cpu %b ldr %b want %b 0", n, cpu_ack, ldr_ack, n == L); end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
    endtask

    task automatic test_reset_busy();
        int edges;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
        @(posedge clk); @(negedge clk);
        tests_run++; if (mem_en !== 1'b1) begin tests_failed++; $display("FAIL rstbusy not busy: got %b want 1", mem_en); end
        reset = 1'b1; cpu_req = 1'b0; ref_mem.delete();
        @(posedge clk); @(negedge clk);
        tests_run++; if ({cpu_ack, ldr_ack, mem_en, mem_we, cpu_stall} !== 5'd0 || mem_addr !== 30'd0 || mem_wdata !== 32'd0
                         || cpu_rdata !== 32'd0 || ldr_rdata !== 32'd0) begin
            tests_failed++; $display("FAIL rstbusy outputs: got ack %b%b en %b we %b addr %h wd %h rd %h %h want all 0",
                                     cpu_ack, ldr_ack, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, ldr_rdata); end
        reset = 1'b0;
        for (int n = 0; n < L + 2; n++) begin
            @(posedge clk); @(negedge clk);
            tests_run++; if (cpu_ack !== 1'b0) begin tests_failed++; $display("FAIL rstbusy late ack n=%0d: got %b want 0", n, cpu_ack); end
        end
        cpu_req = 1'b1; cpu_addr = 32'h48;
        edges = 0;
        while (cpu_ack !== 1'b1 && edges < 40) begin
            @(posedge clk); @(negedge clk); edges++;
        end
        tests_run++; if (edges !== L + 1) begin tests_failed++; $display("FAIL rstbusy latency: got %0d want %0d", edges, L + 1); end
        tests_run++; if (cpu_rdata !== init_word(8'h12)) begin tests_failed++; $display("FAIL rstbusy rdata: got %h want %h", cpu_rdata, init_word(8'h12)); end
        cpu_req = 1'b0;
    endtask

    task automatic test_latency_builds();
        int a1_edge, a15_edge, en1, en15, n1, n15;
        do_reset();
        a1_edge = -1; a15_edge = -1; en1 = 0; en15 = 0; n1 = 0; n15 = 0;
        lb_addr = 32'h48; l1_req = 1'b1; l15_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (l1_en) en1++;
            if (l15_en) en15++;
            tests_run++; if (l1_ldr_ack !== 1'b0 || l15_ldr_ack !== 1'b0) begin tests_failed++; $display("FAIL lat ldr_ack k=%0d: got %b %b want 0 0", k, l1_ldr_ack, l15_ldr_ack); end
            if (l1_ack) begin
                n1++; if (a1_edge < 0) a1_edge = k; l1_req = 1'b0;
                tests_run++; if (l1_rdata !== init_word(8'h12)) begin tests_failed++; $display("FAIL lat1 rdata: got %h want %h", l1_rdata, init_word(8'h12)); end
            end
            if (l15_ack) begin
                n15++; if (a15_edge < 0) a15_edge = k; l15_req = 1'b0;
                tests_run++; if (l15_rdata !== init_word(8'h12)) begin tests_failed++; $display("FAIL lat15 rdata: got %h want %h", l15_rdata, init_word(8'h12)); end
            end
        end
        tests_run++; if (a1_edge !== 2 || n1 !== 1) begin tests_failed++; $display("FAIL lat1 ack: got edge %0d count %0d want 2 1", a1_edge, n1); end
        tests_run++; if (a15_edge !== 16 || n15 !== 1) begin tests_failed++; $display("FAIL lat15 ack: got edge %0d count %0d want 16 1", a15_edge, n15); end
        tests_run++; if (en1 !== 1 || en15 !== 15) begin tests_failed++; $display("FAIL lat mem_en cycles: got %0d %0d want 1 15", en1, en15); end
    endtask

    task automatic test_random();
        int e, grant_edge, free_edge;
        logic g_own, g_we, lastg, exp_ca, exp_la, busy, cpu_el, ldr_el;
        logic [7:0]  g_w;
        logic [31:0] g_wd, exp_crd, exp_lrd, rd;
        do_reset();
        e = 0; grant_edge = -1000; free_edge = 0; lastg = 1'b0;
        g_own = 1'b0; g_we = 1'b0; g_w = 8'd0; g_wd = 32'd0; exp_crd = 32'd0; exp_lrd = 32'd0;
        for (int n = 0; n < 800; n++) begin
            @(posedge clk); e++;
            exp_ca = 1'b0; exp_la = 1'b0;
            if (e == grant_edge + L) begin
                if (!g_we) begin
                    rd = ref_mem.exists(int'(g_w)) ? ref_mem[int'(g_w)] : init_word(g_w);
                    if (g_own) exp_lrd = rd; else exp_crd = rd;
                end
                if (g_own) exp_la = 1'b1; else exp_ca = 1'b1;
            end else if (e >= free_edge) begin
                cpu_el = cpu_req & ~cpu_hold; ldr_el = ldr_req;
                if (cpu_el || ldr_el) begin
                    g_own = (cpu_el && ldr_el) ? ~lastg : ldr_el;
                    lastg = g_own;
                    g_we  = g_own ? ldr_we : cpu_we;
                    g_w   = g_own ? ldr_addr[9:2] : cpu_addr[9:2];
                    g_wd  = g_own ? ldr_wdata : cpu_wdata;
                    if (g_we) ref_mem[int'(g_w)] = g_wd;
                    grant_edge = e; free_edge = e + L + 2;
                end
            end
            busy = (e >= grant_edge) && (e < grant_edge + L);
            @(negedge clk);
            tests_run++; if (cpu_ack !== exp_ca || ldr_ack !== exp_la) begin tests_failed++; $display("FAIL rnd ack e=%0d: got %b%b want %b%b", e, cpu_ack, ldr_ack, exp_ca, exp_la); end
            tests_run++; if (cpu_rdata !== exp_crd || ldr_rdata !== exp_lrd) begin tests_failed++; $display("FAIL rnd rdata e=%0d: got %h %h want %h %h", e, cpu_rdata, ldr_rdata, exp_crd, exp_lrd); end
            tests_run++; if (mem_en !== busy) begin tests_failed++; $display("FAIL rnd mem_en e=%0d: got %b want %b", e, mem_en, busy); end
            tests_run++; if (cpu_stall !== (cpu_req & ~exp_ca)) begin tests_failed++; $display("FAIL rnd stall e=%0d: got %b want %b", e, cpu_stall, cpu_req & ~exp_ca); end
            if (busy) begin
                tests_run++; if (mem_addr !== {22'd0, g_w} || mem_we !== g_we || (g_we && mem_wdata !== g_wd)) begin
                    tests_failed++; $display("FAIL rnd busy e=%0d: got addr %h we %b wd %h want %h %b %h", e, mem_addr, mem_we, mem_wdata, g_w, g_we, g_wd); end
            end
            // CPU requester behaviour.
            if (cpu_req && exp_ca) begin
                if ($urandom_range(1, 0) == 0) cpu_req = 1'b0;
                else begin cpu_we = 1'($urandom_range(1, 0)); cpu_addr = 32'($urandom_range(63, 0)); cpu_wdata = $urandom(); end
            end else if (!cpu_req) begin
                if ($urandom_range(2, 0) == 0) begin cpu_req = 1'b1; cpu_we = 1'($urandom_range(1, 0)); cpu_addr = 32'($urandom_range(63, 0)); cpu_wdata = $urandom(); end
            end else if (busy && !g_own) begin
                cpu_we = 1'($urandom_range(1, 0)); cpu_addr = 32'($urandom_range(63, 0)); cpu_wdata = $urandom();
                if ($urandom_range(9, 0) == 0) cpu_req = 1'b0;
            end
            // Loader requester behaviour.
            if (ldr_req && exp_la) begin
                if ($urandom_range(1, 0) == 0) ldr_req = 1'b0;
                else begin ldr_we = 1'($urandom_range(1, 0)); ldr_addr = 32'($urandom_range(63, 0)); ldr_wdata = $urandom(); end
            end else if (!ldr_req) begin
                if ($urandom_range(2, 0) == 0) begin ldr_req = 1'b1; ldr_we = 1'($urandom_range(1, 0)); ldr_addr = 32'($urandom_range(63, 0)); ldr_wdata = $urandom(); end
            end else if (busy && g_own) begin
                ldr_we = 1'($urandom_range(1, 0)); ldr_addr = 32'($urandom_range(63, 0)); ldr_wdata = $urandom();
                if ($urandom_range(9, 0) == 0) ldr_req = 1'b0;
            end
            if ($urandom_range(19, 0) == 0) cpu_hold = ~cpu_hold;
        end
        cpu_req = 1'b0; ldr_req = 1'b0; cpu_hold = 1'b0;
    endtask

    // Test sequence and summary.
    initial begin
        test_reset();
        test_cpu_read();
        test_ldr_write_cpu_read();
        test_alternation();
        test_hold();
        test_reset_busy();
        test_latency_builds();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
        $fatal(1, "watchdog expired");
    end

endmodule
